// File: rtl/wb_select_pipe.sv
// Write-back source selector: picks a datapath source or an extended immediate,
// tags it with the destination register and buffers it in a 2-entry valid/ready stage.
module wb_select_pipe #(
    parameter int bits      = 8,
    parameter int SOURCES   = 4,
    parameter int IMM_BITS  = 4,
    parameter int ADDR_BITS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(SOURCES)-1:0]   sel,
    input  logic [SOURCES*bits-1:0]      src_data,
    input  logic [IMM_BITS-1:0]          imm,
    input  logic                         imm_sext,
    input  logic                         use_imm,
    input  logic [ADDR_BITS-1:0]         dest_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [bits-1:0]              out_data,
    output logic [ADDR_BITS-1:0]         dest_out,
    output logic                         sel_err,
    output logic [15:0]                  wb_count
);

    localparam int SEL_W = $clog2(SOURCES);
    localparam int SEL_SPAN = 2 ** SEL_W;
    localparam logic [SEL_W:0] NSRC = (SEL_W + 1)'(SOURCES);

    // Sources padded to the full sel range so indexing never leaves the array.
    logic [bits-1:0] src_arr [SEL_SPAN];
    logic [bits-1:0] imm_ext;
    logic [bits-1:0] new_data;
    logic            new_err;
    logic            sel_ok;
    logic            push;
    logic            pop;

    logic [bits-1:0]      head_data_reg;
    logic [ADDR_BITS-1:0] head_dest_reg;
    logic [bits-1:0]      skid_data_reg;
    logic [ADDR_BITS-1:0] skid_dest_reg;
    logic [1:0]           count_reg;
    logic                 sel_err_reg;
    logic [15:0]          wb_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SEL_SPAN; gi++) begin : g_src
            if (gi < SOURCES) begin : g_real
                assign src_arr[gi] = src_data[gi*bits +: bits];
            end else begin : g_pad
                assign src_arr[gi] = '0;
            end
        end

        if (IMM_BITS == bits) begin : g_imm_full
            assign imm_ext = imm;
        end else begin : g_imm_ext
            assign imm_ext = {{(bits-IMM_BITS){imm_sext & imm[IMM_BITS-1]}}, imm};
        end
    endgenerate

    assign sel_ok = ({1'b0, sel} < NSRC);

    always_comb begin
        new_data = '0;
        new_err  = 1'b0;
        if (use_imm) begin
            new_data = imm_ext;
        end else if (sel_ok) begin
            new_data = src_arr[sel];
        end else begin
            new_err = 1'b1;
        end
    end

    assign in_ready  = !rst && (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_data_reg <= '0;
            head_dest_reg <= '0;
            skid_data_reg <= '0;
            skid_dest_reg <= '0;
            count_reg     <= 2'd0;
            sel_err_reg   <= 1'b0;
            wb_count_reg  <= 16'd0;
        end else begin
            if (pop) begin
                wb_count_reg <= wb_count_reg + 16'd1;
            end
            if (push && new_err) begin
                sel_err_reg <= 1'b1;
            end
            // Head is only rewritten when a newer word takes its place, so an
            // empty buffer keeps showing the last delivered word.
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        head_data_reg <= new_data;
                        head_dest_reg <= dest_in;
                    end else begin
                        skid_data_reg <= new_data;
                        skid_dest_reg <= dest_in;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    if (count_reg == 2'd2) begin
                        head_data_reg <= skid_data_reg;
                        head_dest_reg <= skid_dest_reg;
                    end
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    // Push implies count < 2 and pop implies count > 0: count is 1.
                    head_data_reg <= new_data;
                    head_dest_reg <= dest_in;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = head_data_reg;
    assign dest_out = head_dest_reg;
    assign sel_err  = sel_err_reg;
    assign wb_count = wb_count_reg;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Scoreboard bench for wb_select_pipe: a 4-source and a 3-source instance share
// stimulus; a negedge monitor pops expected words and checks every delivery.
module tb_wb_select_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  sel;
    logic [31:0] src_data;
    logic [3:0]  imm;
    logic        imm_sext;
    logic        use_imm;
    logic [2:0]  dest_in;

    logic        in_ready4, out_valid4, sel_err4;
    logic [7:0]  out_data4;
    logic [2:0]  dest_out4;
    logic [15:0] wb_count4;
    logic        in_ready3, out_valid3, sel_err3;
    logic [7:0]  out_data3;
    logic [2:0]  dest_out3;
    logic [15:0] wb_count3;

    always #5 clk = ~clk;

    wb_select_pipe #(.bits(8), .SOURCES(4), .IMM_BITS(4), .ADDR_BITS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .sel(sel), .src_data(src_data), .imm(imm), .imm_sext(imm_sext),
        .use_imm(use_imm), .dest_in(dest_in), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .dest_out(dest_out4),
        .sel_err(sel_err4), .wb_count(wb_count4)
    );

    wb_select_pipe #(.bits(8), .SOURCES(3), .IMM_BITS(4), .ADDR_BITS(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .sel(sel), .src_data(src_data[23:0]), .imm(imm), .imm_sext(imm_sext),
        .use_imm(use_imm), .dest_in(dest_in), .out_valid(out_valid3),
        .out_ready(out_ready), .out_data(out_data3), .dest_out(dest_out3),
        .sel_err(sel_err3), .wb_count(wb_count3)
    );

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
    } exp_t;

    exp_t        q4[$];
    exp_t        q3[$];
    int          assert_cnt = 0;
    int          fail_cnt = 0;
    bit          quiet = 1'b0;
    bit          exp_err3 = 1'b0;
    logic [15:0] exp_wb = 16'd0;
    bit          hold_pend = 1'b0;
    logic [7:0]  held_d;
    logic [2:0]  held_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        assert_cnt++;
        if (act !== req) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: immediate as a signed/unsigned number, source k as byte k of the bus.
    function automatic logic [7:0] model(input int nsrc, input logic [31:0] src, input int s,
                                         input int im, input bit sx, input bit ui);
        int v;
        if (ui) begin
            v = im;
            if (sx && im >= 8) v = im - 16;
            return 8'(v & 255);
        end
        if (s < nsrc) return 8'((src >> (8 * s)) & 32'd255);
        return 8'd0;
    endfunction

    task automatic send(input logic [1:0] s, input logic [31:0] src, input logic [3:0] im,
                        input bit sx, input bit ui, input logic [2:0] d);
        int   waitc;
        exp_t e;
        waitc    = 0;
        sel      = s;
        src_data = src;
        imm      = im;
        imm_sext = sx;
        use_imm  = ui;
        dest_in  = d;
        in_valid = 1'b1;
        while (!in_ready4 && waitc < 100) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!in_ready4) begin
            assert_cnt++;
            fail_cnt++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles, expected 1");
            in_valid = 1'b0;
            return;
        end
        e.a = d;
        e.d = model(4, src, int'(s), int'(im), sx, ui);
        q4.push_back(e);
        e.d = model(3, src, int'(s), int'(im), sx, ui);
        q3.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ui && s >= 2'd3) exp_err3 = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q4.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q4.size() > 0) begin
            assert_cnt++;
            fail_cnt++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", q4.size());
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        exp_err3 = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid4}, 32'd0);
        check("rst_out_data", {24'd0, out_data4}, 32'd0);
        check("rst_dest_out", {29'd0, dest_out4}, 32'd0);
        check("rst_sel_err3", {31'd0, sel_err3}, 32'd0);
        check("rst_wb_count", {16'd0, wb_count4}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready4}, 32'd0);
        check("rst_out_valid3", {31'd0, out_valid3}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_in_ready_hold", {31'd0, in_ready3}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", {31'd0, in_ready4}, 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t e3;
        if (rst) begin
            hold_pend = 1'b0;
            exp_wb    = 16'd0;
            q4.delete();
            q3.delete();
        end else begin
            check("wb_count4", {16'd0, wb_count4}, {16'd0, exp_wb});
            check("wb_count3", {16'd0, wb_count3}, {16'd0, exp_wb});
            check("sel_err4", {31'd0, sel_err4}, 32'd0);
            check("sel_err3", {31'd0, sel_err3}, {31'd0, exp_err3});
            if (hold_pend && out_valid4) begin
                check("stall_data", {24'd0, out_data4}, {24'd0, held_d});
                check("stall_dest", {29'd0, dest_out4}, {29'd0, held_a});
            end
            if (out_valid4 && out_ready) begin
                if (q4.size() == 0 || q3.size() == 0) begin
                    assert_cnt++;
                    fail_cnt++;
                    $display("FAIL unexpected_word: got data=%02h with empty scoreboard, expected none", out_data4);
                end else begin
                    e  = q4.pop_front();
                    e3 = q3.pop_front();
                    check("out_data4", {24'd0, out_data4}, {24'd0, e.d});
                    check("dest_out4", {29'd0, dest_out4}, {29'd0, e.a});
                    check("out_data3", {24'd0, out_data3}, {24'd0, e3.d});
                    check("dest_out3", {29'd0, dest_out3}, {29'd0, e3.a});
                    if (!quiet)
                        $display("deliver #%0d data4=%02h data3=%02h dest=%0d", exp_wb, out_data4, out_data3, dest_out4);
                end
                exp_wb = exp_wb + 16'd1;
            end
            hold_pend = out_valid4 && !out_ready;
            held_d    = out_data4;
            held_a    = dest_out4;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation time limit, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] imm_tab [4];
        bit         sx_tab  [4];
        logic [7:0] res_tab [4];
        logic [1:0] sel_tab [4];
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sel = '0; src_data = '0; imm = '0; imm_sext = 1'b0; use_imm = 1'b0; dest_in = '0;
        do_reset();

        // Immediate extension, including use_imm overriding an out-of-range sel.
        imm_tab = '{4'b1010, 4'b1010, 4'b0111, 4'b1111};
        sx_tab  = '{1'b1, 1'b0, 1'b1, 1'b1};
        res_tab = '{8'hFA, 8'h0A, 8'h07, 8'hFF};
        sel_tab = '{2'd2, 2'd0, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            send(sel_tab[i], 32'hDEADBEEF, imm_tab[i], sx_tab[i], 1'b1, 3'(i));
            check("imm_value", {24'd0, out_data4}, {24'd0, res_tab[i]});
            check("imm_value3", {24'd0, out_data3}, {24'd0, res_tab[i]});
        end
        drain();

        // Basic select with one-cycle latency.
        for (int i = 0; i < 4; i++) begin
            send(2'(i), 32'h44332211, 4'd0, 1'b0, 1'b0, 3'(i + 1));
            check("basic_valid", {31'd0, out_valid4}, 32'd1);
            check("basic_data", {24'd0, out_data4}, 32'(8'h11 * (i + 1)));
            check("basic_dest", {29'd0, dest_out4}, 32'(i + 1));
        end
        drain();

        // Back-pressure: two words fill the buffer, third waits for a pop.
        out_ready = 1'b0;
        send(2'd0, 32'h000000A1, 4'd0, 1'b0, 1'b0, 3'd5);
        send(2'd1, 32'h0000B200, 4'd0, 1'b0, 1'b0, 3'd6);
        check("bp_in_ready_full", {31'd0, in_ready4}, 32'd0);
        check("bp_head_a", {24'd0, out_data4}, 32'hA1);
        fork
            send(2'd2, 32'h00C30000, 4'd0, 1'b0, 1'b0, 3'd7);
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("bp_in_ready_after_pop", {31'd0, in_ready4}, 32'd1);
                check("bp_head_b", {24'd0, out_data4}, 32'hB2);
            end
        join
        drain();

        // Simultaneous push and pop at count 1.
        out_ready = 1'b0;
        send(2'd0, 32'h00000050, 4'd0, 1'b0, 1'b0, 3'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(2'(i % 4), $urandom, 4'd0, 1'b0, 1'b0, 3'(i));
            check("pp_in_ready", {31'd0, in_ready4}, 32'd1);
            check("pp_out_valid", {31'd0, out_valid4}, 32'd1);
        end
        drain();

        // Randomized traffic against random back-pressure.
        fork
            begin
                for (int c = 0; c < 300; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                for (int n = 0; n < 150; n++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge clk);
                        #1;
                    end
                    send(2'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
                end
            end
        join
        drain();

        // Out-of-range sel on the 3-source instance, then reset with two words buffered.
        send(2'd3, 32'h44332211, 4'd0, 1'b0, 1'b0, 3'd2);
        check("err_data3", {24'd0, out_data3}, 32'd0);
        drain();
        out_ready = 1'b0;
        send(2'd1, 32'h44332211, 4'd0, 1'b0, 1'b0, 3'd3);
        send(2'd2, 32'h44332211, 4'd0, 1'b0, 1'b0, 3'd4);
        check("err_sticky", {31'd0, sel_err3}, 32'd1);
        do_reset();
        out_ready = 1'b1;

        // Counter wrap after 65536 deliveries.
        quiet = 1'b1;
        for (int n = 0; n < 65536; n++) begin
            send(2'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'b0, 3'($urandom));
        end
        drain();
        quiet = 1'b0;
        check("wrap_wb_count", {16'd0, wb_count4}, 32'd0);
        check("wrap_wb_count3", {16'd0, wb_count3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/wb_select_pipe.md
# wb_select_pipe

Registered write-back source selector for the 8-bit datapath: picks one of SOURCES datapath results (ALU, load data, etc.) or a zero/sign-extended immediate, tags it with the destination register address, and delivers it to the register file through a 2-entry valid/ready buffer. It sits between the execute stage and the register-file write port, replacing the single-cycle combinational ALU/immediate select with a pipelined, back-pressurable stage.

## Interface
- bits, 8, data width of every source and of the output
- SOURCES, 4, number of datapath sources (≥2)
- IMM_BITS, 4, immediate field width (1..bits)
- ADDR_BITS, 3, destination register address width

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word offered
- in_ready  out  1  stage can accept a word
- sel  in  $clog2(SOURCES)  source index
- src_data  in  SOURCES*bits  flattened sources; source k at [k*bits +: bits]
- imm  in  IMM_BITS  immediate field
- imm_sext  in  1  1 = sign-extend imm, 0 = zero-extend
- use_imm  in  1  1 = deliver extended imm, overrides sel
- dest_in  in  ADDR_BITS  destination register address
- out_valid  out  1  output word valid
- out_ready  in  1  register file accepts word
- out_data  out  bits  selected data
- dest_out  out  ADDR_BITS  destination address for out_data
- sel_err  out  1  sticky: a word was accepted with out-of-range sel
- wb_count  out  16  number of words delivered, wraps modulo 2^16

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Selected value at push: use_imm=1 → imm extended to bits (sign or zero per imm_sext; if IMM_BITS==bits, no extension). Else sel < SOURCES → src_data slice sel. Else → 0, and sel_err set.
- use_imm=1 with out-of-range sel: imm delivered, sel_err not set.
- dest_in captured with data in the same entry.
- Storage: 2-entry in-order FIFO (head + skid); occupancy count 0..2.
- in_ready = !rst && (count < 2); depends only on registered state, never on out_ready or in_valid.
- out_valid = (count > 0); out_data/dest_out = head entry.
- Simultaneous push and pop: count unchanged, order preserved (count 1: new word becomes head next cycle; count 2: push impossible).
- While out_valid && !out_ready, out_data and dest_out stable.
- Entry contents beyond count are don't-care but not visible on outputs; with count 0, out_data/dest_out hold last delivered values (0 after reset).
- sel_err cleared only by rst.
- wb_count increments by 1 on each pop; 0xFFFF + 1 → 0x0000.
- No flush other than rst.

## Timing
- Latency: word pushed at edge N appears with out_valid=1 after edge N (cycle N+1) when buffer was empty.
- Throughput: 1 word/cycle while out_ready held high.
- Back-pressure: after out_ready drops, at most 2 words accepted before in_ready falls.
- in_ready rises the cycle after a pop from full.
- Reset (any cycle, including mid-stall): after the edge with rst=1, count=0, out_valid=0, out_data=0, dest_out=0, sel_err=0, wb_count=0; in_ready=0 while rst is high, 1 the first cycle after release. Buffered words are discarded and not counted.
- No combinational path from any input to out_valid/out_data/dest_out.

## Test plan
- Basic select, out_ready=1: push sel=0..3 with src_data=0x44_33_22_11, dest=1..4 → out_data 0x11,0x22,0x33,0x44 one cycle after each push, dest_out 1..4, wb_count=4.
- Immediate extension: imm=4'b1010, imm_sext=1 → 0xFA; imm_sext=0 → 0x0A; imm=4'b0111, sext=1 → 0x07; use_imm=1 with sel=2 ignores src_data.
- Back-pressure: out_ready=0, stream in 3 words A,B,C → A,B accepted, in_ready=0, out_data=A stable; out_ready=1 → A then B delivered, in_ready=1 after first pop, C accepted then, order A,B,C.
- Simultaneous push/pop at count 1 for 10 consecutive cycles → count stays 1, 10 words in order, wb_count +10.
- Error and reset: SOURCES=3, sel=3, use_imm=0 → out_data=0, sel_err=1 held; assert rst with 2 words buffered → next cycle out_valid=0, sel_err=0, wb_count=0, in_ready=0 until rst drops.
- Counter wrap: preload via 65536 deliveries → wb_count returns to 0x0000.
